mprj_checkpoint_monitor: RTL
============================

Name: mprj_checkpoint_monitor

Overview:
Synthesizable checkpoint-sequence monitor for the user project area. It watches a checkpoint bus, typically the 16 firmware-driven bits mprj_io[31:16], and compares it against a programmable table of expected values that must appear in order. Each value must be held for a programmable stability window, and each step has a per-step timeout. It reports pass, fail, progress and failure cause, so firmware milestone checks (e.g. AB40 -> 003E -> ... -> AB51) run in hardware, in both RTL and GL simulation, and on silicon via logic analyzer (LA) probes.

Parameters:
DATA_W, 16, checkpoint bus width
DEPTH, 8, max table entries (power of 2)
STABLE_CYC, 4, cycles a value must be held before it qualifies (>=1)
TO_W, 24, timeout counter width

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
cfg_we_i  in  1  table write strobe
cfg_addr_i  in  $clog2(DEPTH)  table write index
cfg_data_i  in  DATA_W  expected value
cfg_len_i  in  $clog2(DEPTH)+1  number of entries used (0..DEPTH), sampled at start
cfg_timeout_i  in  TO_W  per-step timeout in cycles; 0 = disabled; sampled at start
cfg_strict_i  in  1  fail on out-of-order value; sampled at start
start_i  in  1  arm/restart pulse
obs_i  in  DATA_W  observed checkpoint bus
busy_o  out  1  run in progress
pass_o  out  1  sequence complete (sticky)
fail_o  out  1  failure (sticky)
fail_code_o  out  2  01 timeout, 10 out-of-order, 00 none
idx_o  out  $clog2(DEPTH)+1  next expected entry index
match_o  out  1  one-cycle pulse per matched entry
last_val_o  out  DATA_W  last qualified value

Behaviour:
- Reset: all outputs 0; state IDLE; filter cleared. Table contents are not reset; they are undefined until written.
- Table write: when cfg_we_i=1 and state != RUN, write table[cfg_addr_i] <= cfg_data_i. Writes during RUN are dropped.
- States:
  - IDLE -> RUN on start_i. Clear pass/fail/fail_code/idx/timeout counter/filter; latch len, timeout, strict.
  - RUN -> PASS when idx reaches len.
  - RUN -> FAIL on timeout or strict violation.
  - PASS/FAIL hold their sticky outputs; start_i from any state, including RUN, restarts as above.
  - busy_o=1 only in RUN.
- Stability filter:
  - obs_q <= obs_i every cycle.
  - stab_cnt clears when obs_i != obs_q (or on start), else saturating increment.
  - Qualify event: a single cycle when stab_cnt transitions to STABLE_CYC-1, i.e. obs_i constant across STABLE_CYC consecutive edges.
  - Qualification fires once per stable run; a constant bus never re-qualifies.
  - After start, the value already present qualifies after STABLE_CYC cycles.
  - last_val_o updates on every qualify event.
- Match: in RUN, a qualify event with value == table[idx] increments idx, pulses match_o on the following cycle, and clears the timeout counter.
  - Equal consecutive entries each need their own qualify event (the value must change and return).
- Non-matching qualified values are ignored unless strict.
- Strict: a qualified value equal to any table[j] with idx < j < len and != table[idx] -> FAIL, fail_code=10.
- Timeout: counter increments each RUN cycle. When it equals cfg_timeout (nonzero) -> FAIL, fail_code=01.
  - A match in the same cycle as timeout wins (match, counter cleared).
- len=0: PASS on the first RUN cycle, so pass_o=1 two cycles after start_i.
- idx_o freezes at failure and reports the failing step.
- Reset mid-run: immediate return to IDLE with all outputs cleared.

Decomposition:
- Package mprj_chk_pkg: fail_code constants (FC_NONE, FC_TIMEOUT, FC_ORDER) and the state enum (IDLE, RUN, PASS, FAIL).
- Sub-module mprj_stable_filter (obs_q, stab_cnt, qualify pulse), parameterised by DATA_W and STABLE_CYC.
- Table and strict comparator array stay in the top module.

Test Plan:
- In-order pass: table {AB40,003E,0044,004A,0050,AB51}, len=6, timeout=1000, STABLE_CYC=4. Drive each value for 10 cycles -> six match_o pulses, idx_o=6, pass_o=1, fail_o=0, last_val_o=AB51.
- Glitch rejection: drive 003E for 2 cycles, then 0000, during step 1 -> no match, idx_o stays 1. Then hold 003E for 4 cycles -> match, idx_o=2.
- Timeout: timeout=50; hold AB40 then freeze the bus at 1234 -> fail_o=1, fail_code_o=01, idx_o=1 exactly 50 RUN cycles after the AB40 match.
- Strict order: strict=1; after AB40, drive stable 0044 -> fail_code_o=10, idx_o=1. Same stimulus with strict=0 -> no failure, still waiting for 003E.
- Boundaries:
  - len=0 -> pass_o two cycles after start.
  - Table {0005,0005}: a constant 0005 yields only idx_o=1; 0005 -> 0000 -> 0005 yields pass.
  - cfg write during RUN leaves the table unchanged.
- Restart/reset: start_i mid-run at idx=3 -> idx_o=0, flags cleared. wb_rst_i mid-run -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/mprj_chk_pkg.sv
// Shared types for the checkpoint monitor: run states and failure codes.
package mprj_chk_pkg;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_TIMEOUT = 2'b01;
    localparam logic [1:0] FC_ORDER   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_e;

endpackage

// File: rtl/mprj_stable_filter.sv
// Stability filter: emits one registered qualify pulse when the bus has been
// constant across STABLE_CYC consecutive edges; a constant bus never re-fires.
module mprj_stable_filter #(
    parameter int DATA_W     = 16,
    parameter int STABLE_CYC = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_obs,
    output logic              o_qual,
    output logic [DATA_W-1:0] o_qval
);

    localparam int            CW  = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0] SAT = CW'(STABLE_CYC - 1);

    logic [DATA_W-1:0] r_obs_q;
    logic [CW-1:0]     r_cnt;
    logic              r_qual;
    logic [DATA_W-1:0] r_qval;

    logic              w_change;
    logic [CW-1:0]     w_cnt_nxt;
    logic              w_qual;

    assign w_change = i_clear || (i_obs != r_obs_q);

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_change) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != SAT) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // Fire only on entry into the saturated count.
    assign w_qual = (w_cnt_nxt == SAT) && (w_change || (r_cnt != SAT));

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_obs_q <= '0;
            r_cnt   <= '0;
            r_qual  <= 1'b0;
            r_qval  <= '0;
        end else begin
            r_obs_q <= i_obs;
            r_cnt   <= w_cnt_nxt;
            r_qual  <= w_qual;
            r_qval  <= i_obs;
        end
    end

    assign o_qual = r_qual;
    assign o_qval = r_qval;

endmodule

// File: rtl/mprj_checkpoint_monitor.sv
// Checkpoint-sequence monitor: matches qualified bus values against an ordered
// table with per-step timeout and optional strict ordering.
module mprj_checkpoint_monitor
    import mprj_chk_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 8,
    parameter int STABLE_CYC = 4,
    parameter int TO_W       = 24
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      cfg_we_i,
    input  logic [$clog2(DEPTH)-1:0]  cfg_addr_i,
    input  logic [DATA_W-1:0]         cfg_data_i,
    input  logic [$clog2(DEPTH):0]    cfg_len_i,
    input  logic [TO_W-1:0]           cfg_timeout_i,
    input  logic                      cfg_strict_i,
    input  logic                      start_i,
    input  logic [DATA_W-1:0]         obs_i,
    output logic                      busy_o,
    output logic                      pass_o,
    output logic                      fail_o,
    output logic [1:0]                fail_code_o,
    output logic [$clog2(DEPTH):0]    idx_o,
    output logic                      match_o,
    output logic [DATA_W-1:0]         last_val_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = AW + 1;

    logic [DATA_W-1:0] r_table [DEPTH];
    state_e            r_state;
    logic [IW-1:0]     r_len;
    logic [IW-1:0]     r_idx;
    logic [TO_W-1:0]   r_timeout;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_strict;
    logic              r_busy;
    logic              r_pass;
    logic              r_fail;
    logic [1:0]        r_code;
    logic              r_match;
    logic [DATA_W-1:0] r_last;

    logic              w_qual;
    logic [DATA_W-1:0] w_qval;
    logic [DATA_W-1:0] w_expect;
    logic              w_later;
    logic [TO_W-1:0]   w_to_inc;

    mprj_stable_filter #(
        .DATA_W     (DATA_W),
        .STABLE_CYC (STABLE_CYC)
    ) u_filter (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_clear (start_i),
        .i_obs   (obs_i),
        .o_qual  (w_qual),
        .o_qval  (w_qval)
    );

    // NOTE: the table is deliberately left out of reset; firmware must write it before use.
    always_ff @(posedge wb_clk_i) begin
        if (cfg_we_i && (r_state != RUN)) begin
            r_table[cfg_addr_i] <= cfg_data_i;
        end
    end

    assign w_expect = r_table[r_idx[AW-1:0]];
    assign w_to_inc = r_to_cnt + 1'b1;

    // A later entry seen early means firmware skipped a milestone.
    always_comb begin
        w_later = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if ((IW'(j) > r_idx) && (IW'(j) < r_len) && (r_table[j] == w_qval)) begin
                w_later = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= IDLE;
            r_len     <= '0;
            r_idx     <= '0;
            r_timeout <= '0;
            r_to_cnt  <= '0;
            r_strict  <= 1'b0;
            r_busy    <= 1'b0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_code    <= FC_NONE;
            r_match   <= 1'b0;
            r_last    <= '0;
        end else begin
            r_match <= 1'b0;
            if (w_qual) begin
                r_last <= w_qval;
            end
            if (start_i) begin
                r_state   <= RUN;
                r_busy    <= 1'b1;
                r_pass    <= 1'b0;
                r_fail    <= 1'b0;
                r_code    <= FC_NONE;
                r_idx     <= '0;
                r_to_cnt  <= '0;
                r_len     <= cfg_len_i;
                r_timeout <= cfg_timeout_i;
                r_strict  <= cfg_strict_i;
            end else if (r_state == RUN) begin
                if (r_idx == r_len) begin
                    r_state <= PASS;
                    r_busy  <= 1'b0;
                    r_pass  <= 1'b1;
                end else if (w_qual && (w_qval == w_expect)) begin
                    r_idx    <= r_idx + 1'b1;
                    r_match  <= 1'b1;
                    r_to_cnt <= '0;
                end else if (w_qual && r_strict && w_later) begin
                    r_state <= FAIL;
                    r_busy  <= 1'b0;
                    r_fail  <= 1'b1;
                    r_code  <= FC_ORDER;
                end else begin
                    r_to_cnt <= w_to_inc;
                    if ((r_timeout != '0) && (w_to_inc == r_timeout)) begin
                        r_state <= FAIL;
                        r_busy  <= 1'b0;
                        r_fail  <= 1'b1;
                        r_code  <= FC_TIMEOUT;
                    end
                end
            end
        end
    end

    assign busy_o      = r_busy;
    assign pass_o      = r_pass;
    assign fail_o      = r_fail;
    assign fail_code_o = r_code;
    assign idx_o       = r_idx;
    assign match_o     = r_match;
    assign last_val_o  = r_last;

endmodule
